// File: rtl/iiitb_sd_ctrl.sv
// Word-level controller around the "1011" Moore detector: serializes words MSB-first,
// counts overlapping matches, reports count/hit/first-position over valid/ready.

module iiitb_sd_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       sequence_in,
  output logic       detector_out,
  output logic [2:0] dbg_state
);
  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    ONE      = 3'd1,
    ONE_Z    = 3'd2,
    ONE_Z_O  = 3'd3,
    FOUND    = 3'd4
  } sd_state_t;

  sd_state_t state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ZERO;
    else       state_q <= state_d;
  end

  // Overlap: after a match the trailing "1" is kept as the start of the next one.
  always_comb begin
    state_d = ZERO;
    case (state_q)
      ZERO:    state_d = sequence_in ? ONE     : ZERO;
      ONE:     state_d = sequence_in ? ONE     : ONE_Z;
      ONE_Z:   state_d = sequence_in ? ONE_Z_O : ZERO;
      ONE_Z_O: state_d = sequence_in ? FOUND   : ONE_Z;
      FOUND:   state_d = sequence_in ? ONE     : ONE_Z;
      default: state_d = ZERO;
    endcase
  end

  always_comb begin
    detector_out = (state_q == FOUND);
    dbg_state    = state_q;
  end
endmodule

module iiitb_sd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4,
  parameter int POS_W   = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_hit,
  output logic [POS_W-1:0]   out_first,
  output logic [2:0]         dbg_state,
  output logic [2:0]         dbg_sd_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready and out_valid are decoded from state only, never from the partner signal.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_FLUSH1 = 3'd2,
    S_FLUSH2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [POS_W-1:0]   idx_q, idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [POS_W-1:0]   first_q, first_d;
  logic               found_q, found_d;
  logic               hit_upd;
  logic [POS_W-1:0]   hit_pos;
  logic               sd_seq;
  logic               sd_out;

  iiitb_sd_fsm u_sd (
    .clock        (clock),
    .reset        (~reset_n),
    .sequence_in  (sd_seq),
    .detector_out (sd_out),
    .dbg_state    (dbg_sd_state)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      first_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      first_q <= first_d;
      found_q <= found_d;
    end
  end

  // The detector output lags its input by one cycle, so a hit seen at index i
  // belongs to bit i-1; the hit belonging to the last bit is seen in FLUSH1.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    count_d = count_q;
    first_d = first_q;
    found_d = found_q;
    hit_upd = 1'b0;
    hit_pos = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          idx_d   = '0;
          count_d = '0;
          first_d = '0;
          found_d = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + POS_W'(1);
        if (sd_out && (idx_q != '0)) begin
          hit_upd = 1'b1;
          hit_pos = idx_q - POS_W'(1);
        end
        if (idx_q == LAST_POS) state_d = S_FLUSH1;
      end
      S_FLUSH1: begin
        if (sd_out) begin
          hit_upd = 1'b1;
          hit_pos = LAST_POS;
        end
        state_d = S_FLUSH2;
      end
      S_FLUSH2: state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        idx_d   = '0;
        count_d = '0;
        first_d = '0;
        found_d = 1'b0;
      end
    endcase
    if (hit_upd) begin
      count_d = count_q + COUNT_W'(1);
      if (!found_q) begin
        first_d = hit_pos;
        found_d = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    sd_seq    = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    out_count = count_q;
    out_hit   = (count_q != '0);
    out_first = first_q;
    dbg_state = state_q;
  end
endmodule

// File: doc/iiitb_sd_ctrl.md
# iiitb_sd_ctrl

Word-level controller for the `iiitb_sd_fsm` "1011" Moore sequence detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an internally instantiated detector. It compensates for the detector's one-cycle output latency and counts overlapping detections. It returns a per-word result (count, hit flag, first-match position) over a second valid/ready handshake, and flushes the detector between words so no match spans two words.

## Interface
- `WIDTH`, default 8: bits per input word; must be ≥ 4.
- `COUNT_W`, default 4: width of `out_count`; must satisfy 2^COUNT_W > WIDTH.
- `POS_W`, default 3: width of `out_first`; must satisfy 2^POS_W ≥ WIDTH.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset. It also resets the detector instance, which receives `~reset_n` on its active-high `reset`.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: controller can accept a word.
- `in_data` in WIDTH: word to scan; bit WIDTH-1 is sent first.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_count` out COUNT_W: number of "1011" matches in the word, overlaps counted.
- `out_hit` out 1: `out_count != 0`.
- `out_first` out POS_W: stream index (0 = MSB) of the bit that completed the first match; 0 when no hit.

## Operation
- Detector instance: `sequence_in` = internal `sd_seq`, `detector_out` = `sd_out`, clocked by `clock`.
- The detector state advances every cycle. `sd_seq` is therefore driven deliberately in every state, and is 0 outside SHIFT.
- Invariant: the detector is in state Zero whenever the controller is in IDLE or DONE. In Zero, input 0 holds Zero.
- FSM states and behaviour:
  - **IDLE**
    - `in_ready`=1, `sd_seq`=0.
    - On `in_valid`: load shift register ← `in_data`, bit index ← 0, count ← 0, first ← 0, found ← 0. Go to SHIFT.
  - **SHIFT** (WIDTH cycles)
    - `sd_seq` = shift register MSB. Shift left each cycle and increment bit index.
    - `sd_out` in this cycle reflects the bit presented in the previous cycle. If `sd_out`=1 and index > 0: count += 1. If `found`=0, also set first ← index-1 and found ← 1.
    - After the cycle with index = WIDTH-1, go to FLUSH1.
  - **FLUSH1**
    - `sd_seq`=0.
    - `sd_out` reflects the last word bit (index WIDTH-1). Apply the same count/first update with position WIDTH-1.
    - Go to FLUSH2.
  - **FLUSH2**
    - `sd_seq`=0. `sd_out` is ignored; it is provably 0.
    - Two consecutive zeros return the detector to Zero from any state.
    - Go to DONE.
  - **DONE**
    - `out_valid`=1. `out_count`, `out_hit` and `out_first` stay stable until accepted.
    - `sd_seq`=0, `in_ready`=0.
    - On `out_ready`: go to IDLE.
- Count never overflows under the parameter rule; the maximum is floor((WIDTH-1)/3).
- Outputs are registered and valid only while `out_valid`=1. They hold their last value otherwise; the bench must not check them then.
- Unknown or illegal encoding: go to IDLE with the same clearing as reset.

## Timing
- Reset (async assert, sync deassert assumed upstream) gives:
  - state IDLE, `in_ready`=1, `out_valid`=0;
  - `out_count`=0, `out_hit`=0, `out_first`=0;
  - `sd_seq`=0, detector in Zero.
- Reset asserted mid-word or in DONE aborts immediately. The partial result is lost and no `out_valid` pulse is produced.
- Acceptance happens on an edge with IDLE ∧ `in_valid`. `out_valid` rises exactly WIDTH+2 cycles after that edge.
- Minimum word period is WIDTH+4 cycles: 1 IDLE + WIDTH SHIFT + 2 FLUSH + 1 DONE.
- `in_ready` depends only on state, never combinationally on `in_valid`. `out_valid` likewise does not depend on `out_ready`.
- Result handshake: `out_valid` stays high with constant data until the edge where `out_ready`=1. Backpressure may last indefinitely.
- `in_valid` held high while busy is ignored until IDLE. The word is sampled only on the accepting edge, so later `in_data` changes have no effect.

## Test plan
- `in_data`=8'b10110110, `out_ready`=1 → `out_count`=2, `out_hit`=1, `out_first`=3; `out_valid` 10 cycles after accept.
- `in_data`=8'b10101011 → count 1, first 7 (match completed by the final bit and captured in FLUSH1).
- `in_data`=8'b00000000 → count 0, hit 0, first 0. Then 8'b10111011 → count 2, first 3.
- Back-to-back words 8'b00000101 then 8'b10000000 → both count 0; the boundary "1011" must not be detected because the flush clears the detector.
- Hold `out_ready`=0 for 20 cycles in DONE → `out_valid`, count and first stable, `in_ready`=0. Then release → IDLE next cycle.
- Assert `reset_n`=0 in the 5th SHIFT cycle of 8'b10111011 → outputs cleared immediately, no result emitted. After release, 8'b10110000 → count 1, first 3.
